// File: rtl/sub_key_store_if.sv
// rtl/sub_key_store_if.sv - host load stream and round-engine read port of the sub-key store
interface sub_key_store_if #(
  parameter int AW = 4,
  parameter int DW = 64
);
  // host load stream
  logic          load_start;
  logic [DW-1:0] key_data;
  logic          key_valid;
  logic          key_ready;
  logic          load_done;
  logic          table_valid;
  logic [AW:0]   key_count;

  // round-engine read port
  logic          reverse;
  logic [AW-1:0] sub_key_address0;
  logic          sub_key_ce0;
  logic [DW-1:0] sub_key_q0;

  modport master (
    output load_start, key_data, key_valid, reverse, sub_key_address0, sub_key_ce0,
    input  key_ready, load_done, table_valid, key_count, sub_key_q0
  );

  modport slave (
    input  load_start, key_data, key_valid, reverse, sub_key_address0, sub_key_ce0,
    output key_ready, load_done, table_valid, key_count, sub_key_q0
  );
endinterface

// File: rtl/sub_key_store.sv
// rtl/sub_key_store.sv - 16 x 64 round-key table with streamed load and registered read port
module sub_key_store #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 64
) (
  input logic          ap_clk,
  input logic          ap_rst,
  sub_key_store_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t        state;
  logic [AW:0]   count_q;
  logic          table_valid_q;
  logic          load_done_q;
  logic [DW-1:0] q0_q;
  logic [DW-1:0] mem [DEPTH];

  logic          accept;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // A fresh load_start always wins over a beat offered in the same cycle.
  assign bus.key_ready = (state == LOAD) && !bus.load_start;
  assign accept        = bus.key_valid && bus.key_ready;
  assign wr_addr       = count_q[AW-1:0];

  // Reverse mode mirrors the table so the same round engine runs decryption.
  assign rd_addr = bus.reverse ? (AW'(DEPTH - 1) - bus.sub_key_address0)
                               : bus.sub_key_address0;

  assign bus.key_count   = count_q;
  assign bus.table_valid = table_valid_q;
  assign bus.load_done   = load_done_q;
  assign bus.sub_key_q0  = q0_q;

  // Load sequencing: word counter, completion pulse and table-valid flag.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state         <= IDLE;
      count_q       <= '0;
      table_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      if (bus.load_start) begin
        state         <= LOAD;
        count_q       <= '0;
        table_valid_q <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              count_q <= count_q + 1'b1;
              if (count_q == (AW+1)'(DEPTH - 1)) begin
                state         <= READY;
                table_valid_q <= 1'b1;
                load_done_q   <= 1'b1;
              end
            end
          end
          READY:   state <= READY;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Table storage; contents survive reset but stay hidden until a full reload.
  always_ff @(posedge ap_clk) begin
    if (accept) begin
      mem[wr_addr] <= key_data_w();
    end
  end

  function automatic logic [DW-1:0] key_data_w();
    return bus.key_data;
  endfunction

  // Registered read; a table that is not fully loaded reads as zero.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      q0_q <= '0;
    end else if (bus.sub_key_ce0) begin
      q0_q <= table_valid_q ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_sub_key_store.sv
// tb/tb_sub_key_store.sv - self-checking bench for sub_key_store
module tb_sub_key_store;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub_key_store_if #(.AW(4), .DW(64)) bus();

  sub_key_store #(.DEPTH(16), .AW(4), .DW(64)) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference model: what the table should hold and what the port should show
  logic [63:0] m_mem [DEPTH];
  bit          m_loading;
  bit          m_valid;
  bit          m_done;
  int          m_cnt;
  logic [63:0] m_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_valid   = 1'b0;
    m_done    = 1'b0;
    m_cnt     = 0;
    m_q       = 64'h0;
  endtask

  task automatic idle_inputs();
    bus.load_start       = 1'b0;
    bus.key_data         = 64'h0;
    bus.key_valid        = 1'b0;
    bus.reverse          = 1'b0;
    bus.sub_key_address0 = 4'h0;
    bus.sub_key_ce0      = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".count"}, 64'(bus.key_count), 64'(m_cnt));
    chk({tag, ".valid"}, 64'(bus.table_valid), 64'(m_valid));
    chk({tag, ".done"},  64'(bus.load_done), 64'(m_done));
    chk({tag, ".q0"},    bus.sub_key_q0, m_q);
  endtask

  // one clock with the inputs currently driven; model advanced from the rules
  task automatic cycle(input string tag);
    int ra;
    bit rdy;
    #1;
    rdy = m_loading && !bus.load_start;
    chk({tag, ".ready"}, 64'(bus.key_ready), 64'(rdy));
    if (bus.sub_key_ce0) begin
      ra   = bus.reverse ? (DEPTH - 1 - int'(bus.sub_key_address0)) : int'(bus.sub_key_address0);
      m_q  = m_valid ? m_mem[ra] : 64'h0;
    end
    m_done = 1'b0;
    if (bus.load_start) begin
      m_loading = 1'b1;
      m_cnt     = 0;
      m_valid   = 1'b0;
    end else if (rdy && bus.key_valid) begin
      m_mem[m_cnt] = bus.key_data;
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_loading = 1'b0;
        m_valid   = 1'b1;
        m_done    = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] v;
    logic [63:0] pat;
    int k;

    idle_inputs();
    model_reset();
    #12;
    check_outputs("reset");
    chk("reset.ready", 64'(bus.key_ready), 64'h0);
    rst = 1'b0;

    // full load with a known pattern
    bus.load_start = 1'b1;
    cycle("start1");
    bus.load_start = 1'b0;
    bus.key_valid  = 1'b1;
    pat = 64'h0101010101010101;
    for (int i = 0; i < DEPTH; i++) begin
      v = pat * 64'(i);
      bus.key_data = v;
      cycle("load1");
    end
    bus.key_valid = 1'b0;
    chk("load1.final_count", 64'(bus.key_count), 64'd16);
    chk("load1.final_done",  64'(bus.load_done), 64'd1);
    cycle("after_load1");

    // forward reads, then hold
    bus.sub_key_ce0 = 1'b1;
    bus.reverse     = 1'b0;
    bus.sub_key_address0 = 4'd0;  cycle("fwd0");
    bus.sub_key_address0 = 4'd5;  cycle("fwd5");
    bus.sub_key_address0 = 4'd15; cycle("fwd15");
    v = pat * 64'd15;
    chk("fwd15.const", bus.sub_key_q0, v);
    bus.sub_key_ce0 = 1'b0;
    bus.sub_key_address0 = 4'd2;
    cycle("hold");
    chk("hold.const", bus.sub_key_q0, v);

    // reverse reads
    bus.sub_key_ce0 = 1'b1;
    bus.reverse     = 1'b1;
    bus.sub_key_address0 = 4'd0;  cycle("rev0");
    bus.sub_key_address0 = 4'd15; cycle("rev15");
    bus.sub_key_address0 = 4'd3;  cycle("rev3");
    v = pat * 64'd12;
    chk("rev3.const", bus.sub_key_q0, v);

    // random read traffic
    for (int i = 0; i < 24; i++) begin
      bus.sub_key_ce0      = 1'($urandom_range(0, 1));
      bus.reverse          = 1'($urandom_range(0, 1));
      bus.sub_key_address0 = 4'($urandom_range(0, 15));
      cycle("rnd_rd");
    end
    idle_inputs();

    // throttled load with random data and reads during the load
    bus.load_start = 1'b1;
    cycle("start2");
    bus.load_start = 1'b0;
    k = 0;
    while (!m_valid && k < 100) begin
      bus.key_valid        = (k % 3 == 0);
      bus.key_data         = rnd64();
      bus.sub_key_ce0      = 1'($urandom_range(0, 1));
      bus.sub_key_address0 = 4'($urandom_range(0, 15));
      cycle("load2");
      k++;
    end
    chk("load2.complete", 64'(bus.table_valid), 64'd1);
    bus.sub_key_ce0 = 1'b0;
    bus.key_valid   = 1'b1;
    bus.key_data    = rnd64();
    cycle("extra_beat");
    bus.key_valid        = 1'b0;
    bus.sub_key_ce0      = 1'b1;
    bus.reverse          = 1'b0;
    bus.sub_key_address0 = 4'd0;
    cycle("entry0_kept");

    // reload collision
    bus.sub_key_ce0 = 1'b0;
    bus.load_start  = 1'b1;
    bus.key_valid   = 1'b1;
    bus.key_data    = 64'hDEAD;
    cycle("collide");
    bus.load_start       = 1'b0;
    bus.key_valid        = 1'b0;
    bus.sub_key_ce0      = 1'b1;
    bus.sub_key_address0 = 4'd2;
    cycle("collide_rd");
    chk("collide_rd.zero", bus.sub_key_q0, 64'h0);

    // seven beats then asynchronous reset between edges
    idle_inputs();
    bus.load_start = 1'b1;
    cycle("start3");
    bus.load_start = 1'b0;
    bus.key_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.key_data = rnd64();
      cycle("load3");
    end
    bus.key_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst.ready", 64'(bus.key_ready), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.sub_key_ce0      = 1'b1;
    bus.sub_key_address0 = 4'd1;
    cycle("post_rst_rd");

    // fresh load while the engine keeps reading address 1
    bus.load_start = 1'b1;
    cycle("start4");
    bus.load_start = 1'b0;
    bus.key_valid  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.key_data = rnd64();
      cycle("load4");
    end
    bus.key_valid = 1'b0;
    cycle("reload_rd1");
    for (int i = 0; i < 8; i++) begin
      bus.reverse          = 1'($urandom_range(0, 1));
      bus.sub_key_address0 = 4'($urandom_range(0, 15));
      cycle("final_rd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
